// File: rtl/axis_burst_reader.sv
// axis_burst_reader: drains an upstream AXIS FIFO in fixed-length bursts.
// A burst starts only once the FIFO holds a whole burst. That lets the consumer
// receive complete packets without underrun. Each burst is closed with tlast.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for enable and fifo_count >= cfg_length (legal length)
// RUN    | moving len_reg beats from s_axis through one output register
// HOLD   | reads done; drain output register, then let fifo_count settle
module axis_burst_reader #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int ADDR_WIDTH       = 9,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        enable,
  input  logic [ADDR_WIDTH:0]         cfg_length,
  input  logic [ADDR_WIDTH:0]         fifo_count,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic                        busy,
  output logic [CNT_WIDTH-1:0]        burst_cnt
);

  localparam int LW = ADDR_WIDTH + 1;
  // Largest legal burst: the whole FIFO (2^ADDR_WIDTH words).
  localparam logic [LW-1:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  // Cycles to wait after the output drains, covering the FIFO count pipeline lag.
  localparam logic [1:0] HOLD_RELOAD = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [1:0]                  r_rst_sync;
  logic                        w_rst_n;
  logic [LW-1:0]               r_len;
  logic [LW-1:0]               r_beat;
  logic [AXIS_TDATA_WIDTH-1:0] r_tdata;
  logic                        r_tvalid;
  logic                        r_tlast;
  logic [CNT_WIDTH-1:0]        r_burst_cnt;
  logic                        r_hold_arm;
  logic [1:0]                  r_hold_tmr;

  logic                        w_s_tready;
  logic                        w_s_hs;
  logic                        w_m_hs;
  logic                        w_last_beat;
  logic                        w_start_ok;
  logic                        w_start_burst;
  logic                        w_drained;

  // Reset synchronizer: assertion takes effect at once, release is aligned to aclk.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  assign w_s_hs      = s_axis_tvalid & w_s_tready;
  assign w_m_hs      = r_tvalid & m_axis_tready;
  assign w_last_beat = (r_beat == (r_len - LW'(1)));
  assign w_drained   = ~r_tvalid | w_m_hs;
  assign w_start_ok  = enable && (cfg_length != '0) && (cfg_length <= MAX_LEN) &&
                       (fifo_count >= cfg_length);

  // State register.
  always_ff @(posedge aclk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode and s_axis acceptance.
  always_comb begin
    w_state_nxt   = r_state;
    w_s_tready    = 1'b0;
    w_start_burst = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt   = S_RUN;
          w_start_burst = 1'b1;
        end
      end
      S_RUN: begin
        w_s_tready = ~r_tvalid | m_axis_tready;
        if (w_s_tready && s_axis_tvalid && w_last_beat) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (r_hold_arm && (r_hold_tmr == 2'd0)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Burst length latch and beat counter; cfg_length is ignored once a burst runs.
  always_ff @(posedge aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_len  <= '0;
      r_beat <= '0;
    end else if (w_start_burst) begin
      r_len  <= cfg_length;
      r_beat <= '0;
    end else if (w_s_hs) begin
      r_beat <= r_beat + LW'(1);
    end
  end

  // Single output register stage; holds data/tlast while the consumer stalls.
  always_ff @(posedge aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else if (w_s_hs) begin
      r_tdata  <= s_axis_tdata;
      r_tvalid <= 1'b1;
      r_tlast  <= w_last_beat;
    end else if (w_m_hs) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end
  end

  // Completed-burst counter, bumped when the tlast beat leaves.
  always_ff @(posedge aclk or negedge w_rst_n) begin
    if (!w_rst_n)              r_burst_cnt <= '0;
    else if (w_m_hs && r_tlast) r_burst_cnt <= r_burst_cnt + CNT_WIDTH'(1);
  end

  // HOLD settle timer: arms once the output is drained, then counts down to zero.
  always_ff @(posedge aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_hold_arm <= 1'b0;
      r_hold_tmr <= HOLD_RELOAD;
    end else if (r_state != S_HOLD) begin
      r_hold_arm <= 1'b0;
      r_hold_tmr <= HOLD_RELOAD;
    end else if (!r_hold_arm) begin
      if (w_drained) r_hold_arm <= 1'b1;
    end else if (r_hold_tmr != 2'd0) begin
      r_hold_tmr <= r_hold_tmr - 2'd1;
    end
  end

  assign s_axis_tready = w_s_tready;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign busy          = (r_state != S_IDLE);
  assign burst_cnt     = r_burst_cnt;

endmodule

// File: tb/tb_axis_burst_reader.sv
// Directed bench for axis_burst_reader. A behavioural FIFO feeds the DUT.
// The FIFO's count output lags by a register stage. Words pushed are a
// running sequence 0,1,2,... so every expected beat value is known in advance.
module tb_axis_burst_reader;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int CW = 32;
  localparam int LW = AW + 1;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b1;
  logic          enable = 1'b0;
  logic [LW-1:0] cfg_length = '0;
  logic [LW-1:0] fifo_count = '0;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b0;
  logic          busy;
  logic [CW-1:0] burst_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int next_word = 0;

  always #5 aclk = ~aclk;

  axis_burst_reader #(
    .AXIS_TDATA_WIDTH(DW),
    .ADDR_WIDTH      (AW),
    .CNT_WIDTH       (CW)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .enable       (enable),
    .cfg_length   (cfg_length),
    .fifo_count   (fifo_count),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .busy         (busy),
    .burst_cnt    (burst_cnt)
  );

  // Upstream FIFO model (first-word-fall-through, registered count).
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [LW-1:0] wr_ptr = '0;
  logic [LW-1:0] rd_ptr = '0;
  logic          wr_en = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] wr_data = '0;

  always @(posedge aclk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (s_axis_tvalid && s_axis_tready) rd_ptr <= rd_ptr + LW'(1);
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
      wr_ptr <= wr_ptr + LW'(1);
    end
    fifo_count <= wr_ptr - rd_ptr;
  end

  assign s_axis_tvalid = (wr_ptr != rd_ptr);
  assign s_axis_tdata  = mem[rd_ptr[AW-1:0]];

  // Record every beat that will handshake on the next rising edge.
  logic [DW-1:0] rx_data [$];
  logic          rx_last [$];

  always @(negedge aclk) begin
    #1;
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      rx_data.push_back(m_axis_tdata);
      rx_last.push_back(m_axis_tlast);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge aclk);
    #1;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      wr_en   = 1'b1;
      wr_data = DW'(next_word);
      next_word++;
    end
    @(negedge aclk);
    wr_en = 1'b0;
  endtask

  task automatic flush_fifo();
    @(negedge aclk);
    flush = 1'b1;
    @(negedge aclk);
    flush = 1'b0;
    idle(2);
  endtask

  task automatic wait_bursts(input logic [CW-1:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk);
      #1;
      if (burst_cnt == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rx(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk);
      #2;
      if (rx_data.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 aresetn = 1'b0;
    idle(2);
    n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); end
    n_checks++; if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast: got %b want 0", m_axis_tlast); end
    n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL rst_s_tready: got %b want 0", s_axis_tready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (burst_cnt !== '0) begin n_fail++; $display("FAIL rst_burst_cnt: got %0d want 0", burst_cnt); end
    n_checks++; if (m_axis_tdata !== '0) begin n_fail++; $display("FAIL rst_tdata: got %0d want 0", m_axis_tdata); end
    @(negedge aclk);
    aresetn = 1'b1;
    idle(4);
  endtask

  // T1: 10 words, len 4 -> bursts 0..3 and 4..7, words 8,9 left behind.
  task automatic test_two_bursts();
    int base;
    bit ok;
    cfg_length = 10'd4;
    m_axis_tready = 1'b1;
    enable = 1'b0;
    push_words(10);
    base = rx_data.size();
    enable = 1'b1;
    wait_bursts(2, 200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t1_done: got burst_cnt %0d want 2", burst_cnt); end
    idle(10);
    n_checks++; if (rx_data.size() !== base + 8) begin n_fail++; $display("FAIL t1_beats: got %0d want 8", rx_data.size() - base); end
    if (rx_data.size() >= base + 8) begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (rx_data[base+i] !== DW'(i) || rx_last[base+i] !== ((i % 4) == 3)) begin
          n_fail++;
          $display("FAIL t1_beat%0d: got data %0d last %b want data %0d last %b",
                   i, rx_data[base+i], rx_last[base+i], i, ((i % 4) == 3));
        end
      end
    end
    n_checks++; if (burst_cnt !== 32'd2) begin n_fail++; $display("FAIL t1_burst_cnt: got %0d want 2", burst_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy: got %b want 0", busy); end
    n_checks++; if (fifo_count !== 10'd2) begin n_fail++; $display("FAIL t1_left: got %0d want 2", fifo_count); end
    n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL t1_s_tready: got %b want 0", s_axis_tready); end
    enable = 1'b0;
    flush_fifo();
  endtask

  // T2: 7 words below len 8 must not start; the 8th word starts the burst promptly.
  task automatic test_threshold();
    int base;
    bit ok;
    bit saw;
    bit found;
    cfg_length = 10'd8;
    enable = 1'b1;
    push_words(7);
    base = rx_data.size();
    saw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      #1;
      if (s_axis_tready || busy) saw = 1'b1;
    end
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL t2_no_start: got activity %b want 0", saw); end
    n_checks++; if (fifo_count !== 10'd7) begin n_fail++; $display("FAIL t2_count: got %0d want 7", fifo_count); end
    push_words(1);
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      #1;
      if (s_axis_tready) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL t2_start_latency: got tready %b want 1 within 3 cycles", found); end
    wait_bursts(3, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t2_done: got burst_cnt %0d want 3", burst_cnt); end
    idle(5);
    n_checks++; if (rx_data.size() !== base + 8) begin n_fail++; $display("FAIL t2_beats: got %0d want 8", rx_data.size() - base); end
    if (rx_data.size() >= base + 8) begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (rx_data[base+i] !== DW'(10 + i) || rx_last[base+i] !== (i == 7)) begin
          n_fail++;
          $display("FAIL t2_beat%0d: got data %0d last %b want data %0d last %b",
                   i, rx_data[base+i], rx_last[base+i], 10 + i, (i == 7));
        end
      end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t2_busy: got %b want 0", busy); end
  endtask

  // T3: len 16 with a randomly stalling consumer.
  task automatic test_random_ready();
    int base;
    bit done;
    bit prev_stall;
    logic [DW-1:0] prev_d;
    logic prev_l;
    cfg_length = 10'd16;
    enable = 1'b1;
    base = rx_data.size();
    push_words(16);
    done = 1'b0;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge aclk);
      m_axis_tready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l) begin
          n_fail++;
          $display("FAIL t3_stable: got valid %b data %0d last %b want valid 1 data %0d last %b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_d, prev_l);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d = m_axis_tdata;
      prev_l = m_axis_tlast;
      if (burst_cnt == 32'd4) begin
        done = 1'b1;
        break;
      end
    end
    m_axis_tready = 1'b1;
    n_checks++; if (!done) begin n_fail++; $display("FAIL t3_done: got burst_cnt %0d want 4", burst_cnt); end
    idle(5);
    n_checks++; if (rx_data.size() !== base + 16) begin n_fail++; $display("FAIL t3_beats: got %0d want 16", rx_data.size() - base); end
    if (rx_data.size() >= base + 16) begin
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (rx_data[base+i] !== DW'(18 + i) || rx_last[base+i] !== (i == 15)) begin
          n_fail++;
          $display("FAIL t3_beat%0d: got data %0d last %b want data %0d last %b",
                   i, rx_data[base+i], rx_last[base+i], 18 + i, (i == 15));
        end
      end
    end
  endtask

  // T4: enable drops mid-burst; burst completes, no further burst starts.
  task automatic test_enable_drop();
    int base;
    bit ok;
    enable = 1'b0;
    cfg_length = 10'd6;
    m_axis_tready = 1'b1;
    push_words(12);
    base = rx_data.size();
    enable = 1'b1;
    wait_rx(base + 2, 50, ok);
    enable = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t4_started: got %0d beats want 2", rx_data.size() - base); end
    wait_bursts(5, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t4_done: got burst_cnt %0d want 5", burst_cnt); end
    idle(20);
    n_checks++; if (rx_data.size() !== base + 6) begin n_fail++; $display("FAIL t4_beats: got %0d want 6", rx_data.size() - base); end
    if (rx_data.size() >= base + 6) begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (rx_data[base+i] !== DW'(34 + i) || rx_last[base+i] !== (i == 5)) begin
          n_fail++;
          $display("FAIL t4_beat%0d: got data %0d last %b want data %0d last %b",
                   i, rx_data[base+i], rx_last[base+i], 34 + i, (i == 5));
        end
      end
    end
    n_checks++; if (burst_cnt !== 32'd5) begin n_fail++; $display("FAIL t4_burst_cnt: got %0d want 5", burst_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t4_busy: got %b want 0", busy); end
    n_checks++; if (fifo_count !== 10'd6) begin n_fail++; $display("FAIL t4_left: got %0d want 6", fifo_count); end
    flush_fifo();
  endtask

  // T5: asynchronous reset mid-burst, then normal operation resumes.
  task automatic test_reset_mid_burst();
    int base;
    bit ok;
    cfg_length = 10'd8;
    m_axis_tready = 1'b1;
    enable = 1'b1;
    base = rx_data.size();
    push_words(8);
    wait_rx(base + 3, 50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t5_started: got %0d beats want 3", rx_data.size() - base); end
    aresetn = 1'b0;
    #1;
    n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL t5_tvalid: got %b want 0", m_axis_tvalid); end
    n_checks++; if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL t5_tlast: got %b want 0", m_axis_tlast); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t5_busy: got %b want 0", busy); end
    n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL t5_s_tready: got %b want 0", s_axis_tready); end
    n_checks++; if (burst_cnt !== '0) begin n_fail++; $display("FAIL t5_burst_cnt: got %0d want 0", burst_cnt); end
    flush_fifo();
    cfg_length = 10'd4;
    @(negedge aclk);
    aresetn = 1'b1;
    idle(4);
    base = rx_data.size();
    push_words(4);
    wait_bursts(1, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t5_resume: got burst_cnt %0d want 1", burst_cnt); end
    idle(5);
    n_checks++; if (rx_data.size() !== base + 4) begin n_fail++; $display("FAIL t5_beats: got %0d want 4", rx_data.size() - base); end
    if (rx_data.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (rx_data[base+i] !== DW'(54 + i) || rx_last[base+i] !== (i == 3)) begin
          n_fail++;
          $display("FAIL t5_beat%0d: got data %0d last %b want data %0d last %b",
                   i, rx_data[base+i], rx_last[base+i], 54 + i, (i == 3));
        end
      end
    end
  endtask

  // T6: illegal lengths 0 and 513 never start; 512 (full FIFO) is a legal burst.
  task automatic test_illegal_len();
    int base;
    int bad;
    bit ok;
    bit saw;
    enable = 1'b1;
    cfg_length = 10'd0;
    m_axis_tready = 1'b1;
    push_words(512);
    base = rx_data.size();
    saw = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      #1;
      if (s_axis_tready || busy) saw = 1'b1;
    end
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL t6_len0: got activity %b want 0", saw); end
    n_checks++; if (fifo_count !== 10'd512) begin n_fail++; $display("FAIL t6_full: got %0d want 512", fifo_count); end
    cfg_length = 10'd513;
    saw = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      #1;
      if (s_axis_tready || busy) saw = 1'b1;
    end
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL t6_len513: got activity %b want 0", saw); end
    n_checks++; if (fifo_count !== 10'd512) begin n_fail++; $display("FAIL t6_no_reads: got %0d want 512", fifo_count); end
    n_checks++; if (rx_data.size() !== base) begin n_fail++; $display("FAIL t6_no_beats: got %0d want 0", rx_data.size() - base); end
    cfg_length = 10'd512;
    wait_bursts(2, 700, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t6_max_done: got burst_cnt %0d want 2", burst_cnt); end
    idle(5);
    n_checks++; if (rx_data.size() !== base + 512) begin n_fail++; $display("FAIL t6_max_beats: got %0d want 512", rx_data.size() - base); end
    bad = 0;
    if (rx_data.size() >= base + 512) begin
      for (int i = 0; i < 512; i++) begin
        if (rx_data[base+i] !== DW'(58 + i) || rx_last[base+i] !== (i == 511)) bad++;
      end
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL t6_max_data: got %0d wrong beats want 0", bad); end
    n_checks++; if (fifo_count !== 10'd0) begin n_fail++; $display("FAIL t6_empty: got %0d want 0", fifo_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t6_busy: got %b want 0", busy); end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_two_bursts();
    test_threshold();
    test_random_ready();
    test_enable_drop();
    test_reset_mid_burst();
    test_illegal_len();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
